// File: rtl/clock_step_pkg.sv
// Shared types and width helpers for the front-panel clock sequencer.
package clock_step_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_edge.sv
// One panel button: 2-FF synchronizer, stable-sample debounce, registered press pulse.
module debounce_edge
    import clock_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any sample matching the current level restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES differing samples flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt   <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/clock_step_controller.sv
// Front-panel clock sequencer: RUN / STEP / HALT state machine driving the CPU clock enable.
module clock_step_controller
    import clock_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_run,
    input  logic btn_step,
    input  logic btn_halt,
    input  logic cpu_halt,
    output logic cpu_clk_en,
    output logic running,
    output logic halted
);

    localparam int            DW      = cnt_width(RUN_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(RUN_DIV - 1);

    // Button lanes: 0 = run, 1 = step, 2 = halt.
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic       run_press;
    logic       step_press;
    logic       halt_press;
    logic       unused_levels;

    assign btn_raw       = {btn_halt, btn_step, btn_run};
    assign run_press     = btn_press[0];
    assign step_press    = btn_press[1];
    assign halt_press    = btn_press[2];
    assign unused_levels = ^btn_level;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        debounce_edge #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_HALT;
            div_cnt <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
        end
    end

    always_comb begin
        state_next = state;
        div_next   = '0;
        case (state)
            ST_HALT: begin
                if (run_press)       state_next = ST_RUN;
                else if (step_press) state_next = ST_STEP;
            end
            ST_RUN: begin
                if (halt_press || cpu_halt) state_next = ST_HALT;
            end
            ST_STEP: state_next = ST_HALT;
            default: state_next = ST_HALT;
        endcase
        // Divider only advances while staying in RUN; entering RUN starts it at 0.
        if (state == ST_RUN && state_next == ST_RUN)
            div_next = (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
    end

    always_comb begin
        cpu_clk_en = (state == ST_STEP) || (state == ST_RUN && div_cnt == DIV_MAX);
        running    = (state == ST_RUN);
        halted     = (state == ST_HALT);
    end

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed bench for clock_step_controller (DEBOUNCE_CYCLES=4, RUN_DIV=3 plus a RUN_DIV=1 twin).
module tb_clock_step_controller;

    logic clk;
    logic rst_n;
    logic btn_run;
    logic btn_step;
    logic btn_halt;
    logic cpu_halt;
    logic cpu_clk_en, running, halted;
    logic en1, run1, halt1;

    int n_vec = 0;
    int n_err = 0;

    clock_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3)) dut (
        .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
        .btn_halt(btn_halt), .cpu_halt(cpu_halt),
        .cpu_clk_en(cpu_clk_en), .running(running), .halted(halted)
    );

    clock_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
        .btn_halt(btn_halt), .cpu_halt(cpu_halt),
        .cpu_clk_en(en1), .running(run1), .halted(halt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick n times; report pulse count and 1-based tick of the first pulse (0 if none).
    task automatic count_ticks(input int n, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (cpu_clk_en) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
    endtask

    // Check RUN cadence: divider index idx0 at the first tick, pulse when index%3==2.
    task automatic check_run(input string tag, input int n, input int idx0, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_en"}, {31'd0, cpu_clk_en}, ((idx0 + i) % 3 == 2) ? 32'd1 : 32'd0);
            chk({tag, "_div1"}, {31'd0, en1}, 32'd1);
            if (cpu_clk_en) pulses++;
        end
    endtask

    initial begin
        int p, f, hcnt;
        logic [6:0] glitch;

        rst_n = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_halt = 1'b0; cpu_halt = 1'b0;
        repeat (3) tick();
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_en", {31'd0, cpu_clk_en}, 32'd0);
        rst_n = 1'b1;

        // Idle: nothing moves
        hcnt = 0; p = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted && !running) hcnt++;
            if (cpu_clk_en) p++;
        end
        chk("idle_halted", hcnt, 20);
        chk("idle_pulses", p, 0);

        // Single step: pulse on tick 8 after driving, exactly once
        btn_step = 1'b1;
        count_ticks(10, p, f);
        chk("step_pulses", p, 1);
        chk("step_first", f, 8);
        chk("step_halted", {31'd0, halted}, 32'd1);
        count_ticks(10, p, f);
        chk("step_hold", p, 0);
        btn_step = 1'b0;
        count_ticks(10, p, f);
        chk("step_release", p, 0);
        btn_step = 1'b1;
        count_ticks(10, p, f);
        chk("step2_pulses", p, 1);
        chk("step2_first", f, 8);
        btn_step = 1'b0;
        count_ticks(10, p, f);

        // Glitches shorter than 4 samples are discarded
        glitch = 7'b0110111;
        p = 0;
        for (int i = 0; i < 17; i++) begin
            btn_step = (i < 7) ? glitch[i] : 1'b0;
            tick();
            if (cpu_clk_en) p++;
        end
        chk("glitch_pulses", p, 0);
        p = 0; f = 0;
        for (int i = 1; i <= 16; i++) begin
            btn_step = (i <= 4);
            tick();
            if (cpu_clk_en) begin
                p++;
                if (f == 0) f = i;
            end
        end
        chk("stable4_pulses", p, 1);
        chk("stable4_first", f, 8);
        btn_step = 1'b0;

        // RUN cadence 0,0,1 and HALT latency
        btn_run = 1'b1;
        count_ticks(7, p, f);
        chk("run_pre_pulses", p, 0);
        chk("run_pre_running", {31'd0, running}, 32'd0);
        btn_run = 1'b0;
        check_run("cad", 30, 0, p);
        chk("cad_pulses", p, 10);
        chk("cad_running", {31'd0, running}, 32'd1);
        btn_halt = 1'b1;
        count_ticks(7, p, f);
        chk("halt_pre_pulses", p, 2);
        chk("halt_pre_running", {31'd0, running}, 32'd1);
        tick();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_en", {31'd0, cpu_clk_en}, 32'd0);
        btn_halt = 1'b0;
        count_ticks(12, p, f);
        chk("halt_post_pulses", p, 0);

        // cpu_halt on a pulse cycle: pulse completes, then HALT
        btn_run = 1'b1;
        count_ticks(7, p, f);
        btn_run = 1'b0;
        check_run("ch", 3, 0, p);
        cpu_halt = 1'b1;
        chk("chalt_en_seen", {31'd0, cpu_clk_en}, 32'd1);
        tick();
        cpu_halt = 1'b0;
        chk("chalt_halted", {31'd0, halted}, 32'd1);
        chk("chalt_en", {31'd0, cpu_clk_en}, 32'd0);
        chk("chalt_div1_en", {31'd0, en1}, 32'd0);
        count_ticks(10, p, f);
        chk("chalt_post", p, 0);

        // Simultaneous RUN+STEP in HALT: RUN wins, no step pulse
        btn_run = 1'b1; btn_step = 1'b1;
        count_ticks(8, p, f);
        chk("sim_pulses", p, 0);
        chk("sim_running", {31'd0, running}, 32'd1);
        btn_run = 1'b0; btn_step = 1'b0;
        check_run("sim", 9, 1, p);
        btn_step = 1'b1;
        check_run("stepign", 15, 10, p);
        btn_step = 1'b0;
        check_run("stepign2", 9, 25, p);

        // HALT press and cpu_halt together
        btn_halt = 1'b1;
        count_ticks(7, p, f);
        chk("both_pre_running", {31'd0, running}, 32'd1);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        chk("both_halted", {31'd0, halted}, 32'd1);
        tick();
        chk("both_halted2", {31'd0, halted}, 32'd1);
        btn_halt = 1'b0;
        count_ticks(10, p, f);
        chk("both_post", p, 0);

        // Async reset mid-RUN, button held through reset release
        btn_run = 1'b1;
        count_ticks(8, p, f);
        chk("rr_running", {31'd0, running}, 32'd1);
        tick();
        tick();
        chk("rr_en_pre", {31'd0, cpu_clk_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_halted", {31'd0, halted}, 32'd1);
        chk("rr_running0", {31'd0, running}, 32'd0);
        chk("rr_en", {31'd0, cpu_clk_en}, 32'd0);
        chk("rr_div1_en", {31'd0, en1}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        f = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (running && f == 0) f = i;
        end
        chk("rr_held_first", f, 8);
        btn_run = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
